// File: rtl/run_dump_monitor_pkg.sv
// Shared types and constants for the run/dump monitor.
package run_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    localparam int          REG_COUNT        = 32;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEF_DATA_START   = 32'h1000_8000;
    localparam int          DEF_DATA_BYTES   = 1024;

    // Number of words in one complete dump (registers, memory, optional checksum).
    function automatic int dump_words(input int data_bytes, input bit with_csum);
        return REG_COUNT + data_bytes / WORD_BYTES + (with_csum ? 1 : 0);
    endfunction

endpackage

// File: rtl/run_dump_monitor_if.sv
// Valid/ready word stream carrying the architectural-state dump.
interface run_dump_monitor_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/run_dump_monitor_out_stage.sv
// Registered valid/ready output register. A load presents a new word (and
// its last flag); the word is held unchanged until the next load or clear.
module dump_out_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        valid,
    output logic [31:0] data,
    output logic        last
);

    // Output word register: clear wins over load so the final transfer empties the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end
    end

endmodule

// File: rtl/run_dump_monitor.sv
// Run/dump monitor: watches the core PC until the exit point (or timeout),
// then streams out the 32 GPRs followed by every data-memory word.
// Optional: define RUN_DUMP_CHECKSUM_EN to append an XOR checksum word
// (XOR of all dumped words, XOR'd with the run cycle count).
module run_dump_monitor
    import run_dump_pkg::*;
#(
    parameter int          DATA_BYTES   = DEF_DATA_BYTES,
    parameter logic [31:0] DATA_START   = DEF_DATA_START,
    parameter int          TIMEOUT      = 100,
    parameter int          DRAIN_INSTRS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm_i,
    input  logic [31:0]           exit_addr_i,
    input  logic [31:0]           pc_i,
    output logic [4:0]            rf_addr_o,
    input  logic [31:0]           rf_data_i,
    output logic [31:0]           dm_addr_o,
    input  logic [31:0]           dm_rdata_i,
    run_dump_monitor_if.master    out,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           cycles_o
);

    localparam int          MEM_WORDS    = DATA_BYTES / WORD_BYTES;
`ifdef RUN_DUMP_CHECKSUM_EN
    localparam int          MEM_LAST     = MEM_WORDS;      // checksum sits one past the memory words
`else
    localparam int          MEM_LAST     = MEM_WORDS - 1;
`endif
    localparam logic [31:0] MEM_WORDS_W  = 32'(MEM_WORDS);
    localparam logic [31:0] MEM_LAST_W   = 32'(MEM_LAST);
    localparam logic [31:0] REG_LAST_W   = 32'(REG_COUNT - 1);
    localparam logic [31:0] TIMEOUT_W    = 32'(TIMEOUT);
    localparam logic [31:0] DRAIN_BYTES  = 32'(WORD_BYTES * DRAIN_INSTRS);

    generate
        if ((DATA_BYTES % WORD_BYTES) != 0 || DATA_BYTES < WORD_BYTES) begin : g_bad_size
            $error("run_dump_monitor: DATA_BYTES must be a positive multiple of 4");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;
    logic [31:0] idx_q, idx_d;
`ifdef RUN_DUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        xfer;
    logic        load, clear, load_last;
    logic [31:0] load_data;
    logic [31:0] mem_fetch;

    assign xfer = out.valid && out.ready;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            idx_q     <= idx_d;
        end
    end

`ifdef RUN_DUMP_CHECKSUM_EN
    // Running XOR of every word that has left the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

    // Read-port addressing. The address looks one word ahead during a
    // transfer so the next word is loaded on the same edge (1 word/cycle);
    // on the last register transfer this briefly points at DATA_START.
    always_comb begin
        rf_addr_o = '0;
        dm_addr_o = '0;
        mem_fetch = xfer ? idx_q + 32'd1 : idx_q;
        case (state_q)
            DUMP_REG: begin
                if (xfer && idx_q == REG_LAST_W) dm_addr_o = DATA_START;
                else if (xfer)                   rf_addr_o = idx_q[4:0] + 5'd1;
                else                             rf_addr_o = idx_q[4:0];
            end
            DUMP_MEM: begin
                if (mem_fetch < MEM_WORDS_W) dm_addr_o = DATA_START + (mem_fetch << 2);
            end
            default: ;
        endcase
    end

    // Next-state logic: arming, run/timeout tracking and dump sequencing.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        idx_d     = idx_q;
        load      = 1'b0;
        clear     = 1'b0;
        load_data = rf_data_i;
        load_last = 1'b0;
`ifdef RUN_DUMP_CHECKSUM_EN
        csum_d    = csum_q;
        if (xfer) csum_d = csum_q ^ out.data;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (arm_i) begin
                    state_d   = RUN;
                    target_d  = exit_addr_i + DRAIN_BYTES;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
`ifdef RUN_DUMP_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            RUN: begin
                // Hit takes priority; cycles hold on the hit edge.
                if (pc_i == target_q) begin
                    state_d   = DUMP_REG;
                    idx_d     = '0;
                    load      = 1'b1;
                    load_data = rf_data_i;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                    if (cycles_d == TIMEOUT_W) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            DUMP_REG: begin
                if (xfer) begin
                    load = 1'b1;
                    if (idx_q == REG_LAST_W) begin
                        state_d   = DUMP_MEM;
                        idx_d     = '0;
                        load_data = dm_rdata_i;
                        load_last = (MEM_LAST_W == 32'd0);
                    end else begin
                        idx_d     = idx_q + 32'd1;
                        load_data = rf_data_i;
                    end
                end
            end
            DUMP_MEM: begin
                if (xfer) begin
                    if (out.last) begin
                        state_d = DONE;
                        idx_d   = '0;
                        clear   = 1'b1;
                    end else begin
                        idx_d     = idx_q + 32'd1;
                        load      = 1'b1;
                        load_last = (idx_q + 32'd1 == MEM_LAST_W);
                        load_data = dm_rdata_i;
`ifdef RUN_DUMP_CHECKSUM_EN
                        if (idx_q + 32'd1 == MEM_WORDS_W)
                            load_data = csum_q ^ out.data ^ cycles_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    dump_out_stage u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .clear     (clear),
        .load_data (load_data),
        .load_last (load_last),
        .valid     (out.valid),
        .data      (out.data),
        .last      (out.last)
    );

    assign busy_o    = (state_q == RUN) || (state_q == DUMP_REG) || (state_q == DUMP_MEM);
    assign done_o    = (state_q == DONE);
    assign timeout_o = timeout_q;
    assign cycles_o  = cycles_q;

endmodule
